tone_synth_param: RTL and testbench

//  Parametrised square-wave note generator for the music player: decodes a 12-bit jianpu note

---
 rtl/tone_synth_param.sv | 217 +++++++++++++++++++++
 tb/tb_tone_synth_param.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_synth_param.sv
// tone_synth_param: decodes a jianpu note code into a glitch-free square wave on speaker.
// Define TONE_GAP_EN to insert an articulation gap of GAP_CYCLES clocks before each strobed note.
module tone_synth_param #(
    parameter int unsigned CLK_HZ     = 5_000_000,
    parameter int unsigned CNT_W      = 14,
    parameter int unsigned GAP_CYCLES = 50_000
) (
    input  logic        clk_5m,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        note_stb,
    input  logic [11:0] din,
    output logic        speaker,
    output logic        playing,
    output logic        bad_code
);
    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    function automatic int unsigned note_hz(input int unsigned idx);
        case (idx)
            0:  return 262;
            1:  return 294;
            2:  return 330;
            3:  return 349;
            4:  return 392;
            5:  return 440;
            6:  return 494;
            7:  return 523;
            8:  return 587;
            9:  return 659;
            10: return 698;
            11: return 784;
            12: return 880;
            13: return 988;
            14: return 1047;
            15: return 1175;
            16: return 1319;
            17: return 1397;
            18: return 1568;
            19: return 1760;
            default: return 1976;
        endcase
    endfunction

    function automatic int unsigned half_of(input int unsigned idx);
        return CLK_HZ / (2 * note_hz(idx));
    endfunction

    function automatic bit table_fits();
        for (int unsigned i = 0; i < 21; i++) begin
            if (64'(half_of(i)) >= (64'd1 << CNT_W)) return 1'b0;
        end
        return 1'b1;
    endfunction

    if (!table_fits()) begin : g_cnt_w_check
        $error("CNT_W too narrow for the half-period of the lowest note at CLK_HZ");
    end
    if (GAP_CYCLES == 0) begin : g_gap_check
        $error("GAP_CYCLES must be at least 1");
    end

    logic [CNT_W-1:0] half_tab [32];
    for (genvar g = 0; g < 32; g++) begin : g_half
        assign half_tab[g] = (g < 21) ? CNT_W'(half_of(g)) : '0;
    end

    // Decode: dec_half of zero stands for a rest (legal or not).
    logic             lo_ok, mid_ok, hi_ok, is_rest, is_bad;
    logic [4:0]       idx;
    logic [CNT_W-1:0] dec_half;

    always_comb begin
        lo_ok   = (din[11:3] == '0) && (din[2:0] != '0);
        mid_ok  = (din[11:7] == '0) && (din[3:0] == '0) && (din[6:4] != '0);
        hi_ok   = (din[11] == 1'b0) && (din[7:0] == '0) && (din[10:8] != '0);
        is_rest = (din == '0);
        is_bad  = !(lo_ok || mid_ok || hi_ok || is_rest);
        idx     = '0;
        if (lo_ok)       idx = 5'(din[2:0]) - 5'd1;
        else if (mid_ok) idx = 5'(din[6:4]) + 5'd6;
        else if (hi_ok)  idx = 5'(din[10:8]) + 5'd13;
        dec_half = (lo_ok || mid_ok || hi_ok) ? half_tab[idx] : '0;
    end

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cur_half, cur_half_n, pend_half, pend_half_n;
    logic             spk, spk_n, pend_v, pend_v_n, bad_q, bad_n;
`ifdef TONE_GAP_EN
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GAP_W-1:0] gap_cnt, gap_n;
`endif

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cur_half_n  = cur_half;
        spk_n       = spk;
        pend_v_n    = pend_v;
        pend_half_n = pend_half;
        bad_n       = enable && note_stb && is_bad;
`ifdef TONE_GAP_EN
        gap_n       = gap_cnt;
`endif
        if (!enable) begin
            state_n     = IDLE;
            cnt_n       = '0;
            spk_n       = 1'b0;
            pend_v_n    = 1'b0;
            pend_half_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    pend_v_n = 1'b0;
                    if (note_stb && dec_half != '0) begin
                        state_n    = TONE;
                        cur_half_n = dec_half;
                        cnt_n      = dec_half - ONE;
                    end else if (!note_stb && pend_v && pend_half != '0) begin
                        state_n    = TONE;
                        cur_half_n = pend_half;
                        cnt_n      = pend_half - ONE;
                    end
                end
                TONE: begin
                    cnt_n = cnt - ONE;
                    // Expiry consumes the pending value held before this edge; a strobe
                    // on the same edge becomes pending for the following expiry.
                    if (cnt == '0) begin
                        pend_v_n = 1'b0;
                        if (!pend_v) begin
                            spk_n = !spk;
                            cnt_n = cur_half - ONE;
                        end else if (pend_half == '0) begin
                            spk_n   = 1'b0;
                            state_n = IDLE;
                            cnt_n   = '0;
                        end else begin
`ifdef TONE_GAP_EN
                            spk_n      = 1'b0;
                            state_n    = GAP;
                            cnt_n      = '0;
                            cur_half_n = pend_half;
                            gap_n      = GAP_W'(GAP_CYCLES - 1);
`else
                            spk_n      = !spk;
                            cur_half_n = pend_half;
                            cnt_n      = pend_half - ONE;
`endif
                        end
                    end
                    if (note_stb) begin
                        pend_v_n    = 1'b1;
                        pend_half_n = dec_half;
                    end
                end
`ifdef TONE_GAP_EN
                GAP: begin
                    gap_n = gap_cnt - GAP_W'(1);
                    if (gap_cnt == '0) begin
                        pend_v_n = 1'b0;
                        state_n  = TONE;
                        cnt_n    = cur_half - ONE;
                        if (pend_v && pend_half == '0) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                        end else if (pend_v) begin
                            cur_half_n = pend_half;
                            cnt_n      = pend_half - ONE;
                        end
                    end
                    if (note_stb) begin
                        pend_v_n    = 1'b1;
                        pend_half_n = dec_half;
                    end
                end
`endif
                default: begin
                    state_n = IDLE;
                    spk_n   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_5m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_half  <= '0;
            spk       <= 1'b0;
            pend_v    <= 1'b0;
            pend_half <= '0;
            bad_q     <= 1'b0;
`ifdef TONE_GAP_EN
            gap_cnt   <= '0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cur_half  <= cur_half_n;
            spk       <= spk_n;
            pend_v    <= pend_v_n;
            pend_half <= pend_half_n;
            bad_q     <= bad_n;
`ifdef TONE_GAP_EN
            gap_cnt   <= gap_n;
`endif
        end
    end

    assign speaker  = spk;
    assign playing  = (state != IDLE);
    assign bad_code = bad_q;
endmodule

// File: tb/tb_tone_synth_param.sv
// Self-checking bench for tone_synth_param: timestamp-based reference model checked every
// cycle, a decode vector table, and hand sequences for note changes, rests, gap and reset.
module tb_tone_synth_param;
    localparam int GAP = 100;
`ifdef TONE_GAP_EN
    localparam bit GAP_MODE = 1'b1;
`else
    localparam bit GAP_MODE = 1'b0;
`endif
    localparam int REP_LOW = GAP_MODE ? (4780 + GAP) : 4780;

    logic        clk_5m = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        note_stb = 1'b0;
    logic [11:0] din = '0;
    logic        speaker, playing, bad_code;

    tone_synth_param #(.CLK_HZ(5_000_000), .CNT_W(14), .GAP_CYCLES(GAP)) dut (
        .clk_5m(clk_5m), .rst_n(rst_n), .enable(enable), .note_stb(note_stb),
        .din(din), .speaker(speaker), .playing(playing), .bad_code(bad_code)
    );

    always #5 clk_5m = ~clk_5m;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int hz_tab [21] = '{262, 294, 330, 349, 392, 440, 494,
                        523, 587, 659, 698, 784, 880, 988,
                        1047, 1175, 1319, 1397, 1568, 1760, 1976};

    // Reference model state: absolute cycle numbers of the next events.
    bit m_on, m_spk, m_bad, m_pv, m_gap;
    int m_half, m_next, m_ph, m_gap_end;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -1 = illegal code, 0 = rest, otherwise half-period in clocks.
    function automatic int ref_half(input logic [11:0] code);
        int nz, oct, deg;
        logic [3:0] nib;
        nz = 0; oct = 0; deg = 0;
        if (code == 12'h000) return 0;
        for (int k = 0; k < 3; k++) begin
            nib = code[4*k +: 4];
            if (nib != 4'h0) begin
                nz++;
                oct = k;
                deg = int'(nib);
            end
        end
        if (nz != 1 || deg > 7) return -1;
        return 5_000_000 / (2 * hz_tab[oct*7 + deg - 1]);
    endfunction

    task automatic model_reset();
        m_on = 0; m_spk = 0; m_bad = 0; m_pv = 0; m_gap = 0; m_ph = 0;
    endtask

    task automatic model_edge();
        int h;
        if (!rst_n || !enable) begin
            model_reset();
            return;
        end
        h = ref_half(din);
        m_bad = note_stb && (h < 0);
        if (h < 0) h = 0;
        if (!m_on) begin
            if (note_stb ? (h > 0) : (m_pv && m_ph > 0)) begin
                m_half = note_stb ? h : m_ph;
                m_on = 1;
                m_next = cyc + m_half;
            end
            m_pv = 0;
            return;
        end
        if (m_gap) begin
            if (cyc == m_gap_end) begin
                m_gap = 0;
                if (m_pv && m_ph == 0) m_on = 0;
                else begin
                    if (m_pv) m_half = m_ph;
                    m_next = cyc + m_half;
                end
                m_pv = 0;
            end
        end else if (cyc == m_next) begin
            if (m_pv && m_ph == 0) begin
                m_on = 0;
                m_spk = 0;
            end else if (m_pv && GAP_MODE) begin
                m_spk = 0;
                m_half = m_ph;
                m_gap = 1;
                m_gap_end = cyc + GAP;
            end else begin
                if (m_pv) m_half = m_ph;
                m_spk = !m_spk;
                m_next = cyc + m_half;
            end
            m_pv = 0;
        end
        if (note_stb) begin
            m_pv = 1;
            m_ph = h;
        end
    endtask

    task automatic step();
        @(posedge clk_5m);
        cyc++;
        model_edge();
        #1;
        check("model_speaker", speaker, m_spk);
        check("model_playing", playing, m_on);
        check("model_bad_code", bad_code, m_bad);
    endtask

    task automatic strobe(input logic [11:0] code);
        din = code;
        note_stb = 1'b1;
        step();
        note_stb = 1'b0;
    endtask

    task automatic go_idle();
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
    endtask

    task automatic wait_toggle(input string name, input int limit, output int t);
        logic s0;
        s0 = speaker;
        t = -1;
        for (int i = 0; i < limit; i++) begin
            step();
            if (speaker !== s0) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no speaker toggle within %0d cycles", name, limit);
            t = cyc;
        end
    endtask

    typedef struct {
        logic [11:0] din;
        logic        bad;
        logic        play;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int t0, ta, tb, tc, td;
        logic [11:0] last_code;

        vecs[0]  = '{12'h010, 1'b0, 1'b1};
        vecs[1]  = '{12'h000, 1'b0, 1'b0};
        vecs[2]  = '{12'h011, 1'b1, 1'b0};
        vecs[3]  = '{12'h008, 1'b1, 1'b0};
        vecs[4]  = '{12'h700, 1'b0, 1'b1};
        vecs[5]  = '{12'h001, 1'b0, 1'b1};
        vecs[6]  = '{12'h007, 1'b0, 1'b1};
        vecs[7]  = '{12'h800, 1'b1, 1'b0};
        vecs[8]  = '{12'h080, 1'b1, 1'b0};
        vecs[9]  = '{12'h101, 1'b1, 1'b0};
        vecs[10] = '{12'h00F, 1'b1, 1'b0};
        vecs[11] = '{12'h070, 1'b0, 1'b1};
        vecs[12] = '{12'h400, 1'b0, 1'b1};
        vecs[13] = '{12'hFFF, 1'b1, 1'b0};

        model_reset();
        repeat (3) step();
        check("reset_speaker", speaker, 0);
        check("reset_playing", playing, 0);
        check("reset_bad_code", bad_code, 0);
        rst_n = 1'b1;
        enable = 1'b1;
        step();

        // Mid-1: first rise after H, then period 2H, then a strobe on an expiry edge.
        strobe(12'h010);
        t0 = cyc;
        check("t1_playing", playing, 1);
        wait_toggle("t1_rise", 6000, ta);
        check("t1_first_rise", ta - t0, 4780);
        check("t1_speaker_high", speaker, 1);
        wait_toggle("t1_fall", 6000, tb);
        wait_toggle("t1_rise2", 6000, tc);
        check("t1_period", tc - ta, 9560);
        while (cyc < tc + 4780 - 1) step();
        strobe(12'h700);
        check("same_edge_toggle", speaker, 0);
        wait_toggle("same_edge_next", 6000, td);
        check("same_edge_old_half", td - (tc + 4780), 4780);
        repeat (100) step();
        enable = 1'b0;
        step();
        check("disable_speaker", speaker, 0);
        check("disable_playing", playing, 0);
        din = 12'h010;
        note_stb = 1'b1;
        step();
        check("disable_blocks_strobe", playing, 0);
        enable = 1'b1;
        step();
        note_stb = 1'b0;
        check("reenable_strobe", playing, 1);

        // Mid-5 changed to high-7 mid-half.
        go_idle();
        strobe(12'h050);
        t0 = cyc;
        wait_toggle("t2_rise", 4000, ta);
        check("t2_first_rise", ta - t0, 3188);
        repeat (1000) step();
        strobe(12'h700);
        wait_toggle("t2_fall", 4000, tb);
        check("t2_half_completes", tb - ta, 3188);
        wait_toggle("t2_new1", 4000, tc);
        check("t2_new_half1", tc - tb, 1265);
        wait_toggle("t2_new2", 4000, td);
        check("t2_new_half2", td - tc, 1265);

        // Low-1 then rest.
        go_idle();
        strobe(12'h001);
        t0 = cyc;
        wait_toggle("t3_rise", 10000, ta);
        check("t3_first_rise", ta - t0, 9541);
        repeat (50) step();
        strobe(12'h000);
        wait_toggle("t3_fall", 10000, tb);
        check("t3_rest_at_expiry", tb - ta, 9541);
        check("t3_playing_off", playing, 0);
        repeat (300) step();
        check("t3_silent_speaker", speaker, 0);
        check("t3_silent_playing", playing, 0);

        // Decode table from IDLE.
        foreach (vecs[i]) begin
            go_idle();
            strobe(vecs[i].din);
            check($sformatf("vec%0d_bad_code", i), bad_code, vecs[i].bad);
            check($sformatf("vec%0d_playing", i), playing, vecs[i].play);
            step();
            check($sformatf("vec%0d_bad_pulse_end", i), bad_code, 0);
        end

        // Repeat of the playing note: seamless, or gapped with TONE_GAP_EN.
        go_idle();
        strobe(12'h010);
        wait_toggle("t5_rise", 6000, ta);
        repeat (10) step();
        strobe(12'h010);
        wait_toggle("t5_fall", 6000, tb);
        check("t5_fall", tb - ta, 4780);
        wait_toggle("t5_rise2", 6000, tc);
        check("t5_low_time", tc - tb, REP_LOW);

        // Asynchronous reset mid-half, then a fresh note.
        repeat (100) step();
        strobe(12'h700);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_speaker", speaker, 0);
        check("async_rst_playing", playing, 0);
        check("async_rst_bad_code", bad_code, 0);
        repeat (2) step();
        rst_n = 1'b1;
        strobe(12'h010);
        t0 = cyc;
        wait_toggle("t6_rise", 6000, ta);
        check("t6_first_rise", ta - t0, 4780);

        // Randomised strobes and mutes against the model.
        go_idle();
        last_code = 12'h010;
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 2999) == 0) begin
                enable = 1'b0;
                step();
                enable = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                case ($urandom_range(0, 3))
                    0: last_code = 12'($urandom_range(1, 7)) << (4 * $urandom_range(0, 2));
                    1: last_code = 12'h000;
                    2: last_code = 12'($urandom);
                    default: ;
                endcase
                strobe(last_code);
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
